// File: rtl/spi_pkg.sv
// Shared definitions for the 16-bit SPI responder and the benches that drive it.
package spi_pkg;

   localparam int SPI_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SKIP  = 2'd1,
      SHIFT = 2'd2
   } spi_state_t;

   // Command opcodes of the emulated inertial sensor and A2D, sent in the upper byte.
   typedef enum logic [7:0] {
      CMD_WHO_AM_I = 8'h8F,
      CMD_RD_GYRO  = 8'hA6,
      CMD_RD_ACCEL = 8'hA8,
      CMD_A2D_CH0  = 8'h00,
      CMD_A2D_CH1  = 8'h08
   } spi_cmd_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered single-clk rise/fall pulses and a
// selectable reset value so idle-high pins do not produce edges out of reset.
module spi_sync_edge #(
   parameter int   STAGES = 2,
   parameter logic PRESET = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;
   logic              prev;

   assign level = sync[STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= {STAGES{PRESET}};
         prev <= PRESET;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], din};
         prev <= level;
         rise <= level & ~prev;
         fall <= ~level & prev;
      end
   end

endmodule

// File: rtl/spi_slv16.sv
// Mode-3 SPI responder: oversampled pins, skip-first-fall shifter, rx/tx words
// exchanged with the fabric, rdy/err flags for completed and aborted frames.
module spi_slv16
   import spi_pkg::*;
#(
   parameter int WIDTH       = SPI_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             SS_n,
   input  logic             SCLK,
   input  logic             MOSI,
   output logic             MISO,
   output logic             miso_en,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             wrt,
   output logic [WIDTH-1:0] rx_data,
   output logic             rdy,
   input  logic             clr_rdy,
   output logic             err
);

   localparam int             CW       = $clog2(WIDTH + 2);
   localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH + 1);

   spi_state_t       state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] tx_buf;
   logic [CW-1:0]    bit_cnt;
   logic             mosi_smpl;

   logic ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_lvl;
   logic ss_level_unused, sclk_level_unused, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_ss (
      .clk(clk), .rst(rst), .din(SS_n),
      .level(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_sclk (
      .clk(clk), .rst(rst), .din(SCLK),
      .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .PRESET(1'b0)) u_mosi (
      .clk(clk), .rst(rst), .din(MOSI),
      .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   // MISO idles high while deselected, regardless of what the shifter holds.
   assign miso_en = (state != IDLE);
   assign MISO    = miso_en ? sr[WIDTH-1] : 1'b1;

   always_ff @(posedge clk) begin
      if (rst)      tx_buf <= '0;
      else if (wrt) tx_buf <= tx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sr        <= '0;
         bit_cnt   <= '0;
         mosi_smpl <= 1'b0;
         rx_data   <= '0;
         rdy       <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         // NOTE: with non-blocking assignments the last one in program order wins,
         // so the completion set further down overrides this clear in the same cycle.
         if (clr_rdy) rdy <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ss_fall) begin
                  sr      <= tx_buf;
                  bit_cnt <= '0;
                  rdy     <= 1'b0;
                  state   <= SKIP;
               end
            end
            SKIP, SHIFT: begin
               if (ss_rise) begin
                  state <= IDLE;
                  if (bit_cnt == CNT_FULL) begin
                     rx_data <= {sr[WIDTH-2:0], mosi_smpl};
                     rdy     <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end else if (sclk_rise) begin
                  mosi_smpl <= mosi_lvl;
                  if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CW'(1);
               end else if (sclk_fall) begin
                  if (state == SKIP) state <= SHIFT;
                  else               sr    <= {sr[WIDTH-2:0], mosi_smpl};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slv16.sv
// Directed and table-driven bench for spi_slv16 acting against a mode-3 master model.
module tb_spi_slv16;
   import spi_pkg::*;

   localparam int W   = SPI_WIDTH;
   localparam int SS  = 2;
   localparam int LAT = SS + 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         SS_n = 1'b1, SCLK = 1'b1, MOSI = 1'b0;
   logic         MISO, miso_en, rdy, err;
   logic         wrt = 1'b0, clr_rdy = 1'b0;
   logic [W-1:0] tx_data = '0;
   logic [W-1:0] rx_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   spi_slv16 #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
      .MISO(MISO), .miso_en(miso_en), .tx_data(tx_data), .wrt(wrt),
      .rx_data(rx_data), .rdy(rdy), .clr_rdy(clr_rdy), .err(err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_wrt(input logic [W-1:0] v);
      @(negedge clk);
      tx_data = v;
      wrt     = 1'b1;
      @(negedge clk);
      wrt     = 1'b0;
   endtask

   // Mode-3 master: MSB driven at SS_n fall, first SCLK fall skipped, MISO taken just
   // before each rise; then watches rdy/err for 8 clk after SS_n rises.
   task automatic spi_xfer(input logic [W-1:0] mosi_word, input int half, input int nbits,
                           output logic [W-1:0] miso_word, output int lat,
                           output int hi_cnt, output int err_cnt);
      logic [W-1:0] sh;
      sh        = mosi_word;
      miso_word = '0;
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = sh[W-1];
      repeat (half) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         if (i > 0) begin
            sh   = sh << 1;
            MOSI = sh[W-1];
         end
         repeat (half) @(negedge clk);
         miso_word = {miso_word[W-2:0], MISO};
         SCLK = 1'b1;
         repeat (half) @(negedge clk);
      end
      SS_n    = 1'b1;
      lat     = -1;
      hi_cnt  = 0;
      err_cnt = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (rdy) begin
            hi_cnt++;
            if (lat < 0) lat = k;
         end
         if (err) err_cnt++;
      end
      MOSI = 1'b0;
   endtask

   typedef struct {
      logic [W-1:0] tx;
      logic [W-1:0] mosi;
      int           half;
      int           nbits;
      logic [W-1:0] exp_miso;
      logic [W-1:0] exp_rx;
      int           exp_lat;
      int           exp_err;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [W-1:0] mw, tx_r, mo_r;
      int lat, hi, ec;
      bit seen;

      vecs[0] = '{16'hA5C3, 16'h1234, 16, 16, 16'hA5C3, 16'h1234, LAT, 0};
      vecs[1] = '{16'h0F0F, 16'h8001,  4, 16, 16'h0F0F, 16'h8001, LAT, 0};
      vecs[2] = '{16'h7E81, 16'hDEAD,  6,  9, 16'h0000, 16'h8001,  -1, 1};
      vecs[3] = '{16'h1357, 16'hCAFE,  5, 17, 16'h0000, 16'h8001,  -1, 1};
      vecs[4] = '{16'hFFFF, 16'h0001,  4, 16, 16'hFFFF, 16'h0001, LAT, 0};

      // Reset state
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset MISO", MISO, 1);
      check("reset miso_en", miso_en, 0);
      check("reset rdy", rdy, 0);
      check("reset err", err, 0);
      check("reset rx_data", rx_data, 0);

      // Table-driven exchanges, including short and long frames
      foreach (vecs[i]) begin
         do_wrt(vecs[i].tx);
         spi_xfer(vecs[i].mosi, vecs[i].half, vecs[i].nbits, mw, lat, hi, ec);
         if (vecs[i].nbits == W) check($sformatf("vec%0d miso word", i), mw, vecs[i].exp_miso);
         check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_rx);
         check($sformatf("vec%0d rdy latency", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d err pulses", i), ec, vecs[i].exp_err);
         check($sformatf("vec%0d miso_en idle", i), miso_en, 0);
         check($sformatf("vec%0d MISO idle", i), MISO, 1);
      end

      // Back-to-back with a tx_buf update in the middle of the first frame
      do_wrt(16'h2222);
      fork
         spi_xfer(16'hFFFF, 4, 16, mw, lat, hi, ec);
         begin
            repeat (60) @(negedge clk);
            tx_data = 16'h8001;
            wrt     = 1'b1;
            @(negedge clk);
            wrt     = 1'b0;
         end
      join
      check("b2b first miso word", mw, 16'h2222);
      check("b2b first rx_data", rx_data, 16'hFFFF);
      check("b2b first rdy latency", lat, LAT);
      check("b2b rdy before second frame", rdy, 1);
      fork
         spi_xfer(16'h0000, 4, 16, mw, lat, hi, ec);
         begin
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
               @(posedge clk);
               #1;
               if (miso_en) seen = 1'b1;
            end
            check("b2b second frame start seen", seen, 1);
            check("b2b rdy cleared at SS fall", rdy, 0);
         end
      join
      check("b2b second miso word", mw, 16'h8001);
      check("b2b second rx_data", rx_data, 16'h0000);
      check("b2b second err pulses", ec, 0);

      // Set beats clr_rdy
      clr_rdy = 1'b1;
      spi_xfer(16'h3C5A, 4, 16, mw, lat, hi, ec);
      clr_rdy = 1'b0;
      check("clr_rdy rdy latency", lat, LAT);
      check("clr_rdy rdy high cycles", hi, 1);
      check("clr_rdy rx_data", rx_data, 16'h3C5A);

      // Reset in the middle of a frame, after the 7th rise
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = 1'b1;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         SCLK = 1'b0;
         repeat (8) @(negedge clk);
         SCLK = 1'b1;
         repeat (8) @(negedge clk);
      end
      check("mid-frame miso_en", miso_en, 1);
      rst  = 1'b1;
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(posedge clk);
      #1;
      check("mid reset MISO", MISO, 1);
      check("mid reset miso_en", miso_en, 0);
      check("mid reset rdy", rdy, 0);
      check("mid reset err", err, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ec  = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (err || rdy || miso_en) ec++;
      end
      check("post reset quiet cycles", ec, 0);
      check("post reset rx_data", rx_data, 0);
      do_wrt(16'h5555);
      spi_xfer(16'hBEEF, 4, 16, mw, lat, hi, ec);
      check("post reset miso word", mw, 16'h5555);
      check("post reset rx_data BEEF", rx_data, 16'hBEEF);
      check("post reset rdy latency", lat, LAT);
      check("post reset err pulses", ec, 0);

      // Minimum SCLK phase, random words
      for (int n = 0; n < 200; n++) begin
         tx_r = W'($urandom);
         mo_r = W'($urandom);
         do_wrt(tx_r);
         spi_xfer(mo_r, LAT, 16, mw, lat, hi, ec);
         check($sformatf("rand%0d miso word", n), mw, tx_r);
         check($sformatf("rand%0d rx_data", n), rx_data, mo_r);
         check($sformatf("rand%0d err pulses", n), ec, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_slv16.md
Name: spi_slv16

Overview:
- 16-bit SPI responder (slave). It is the other end of the team's 16-bit SPI master.
- Its job is to model or emulate the inertial sensor and A2D devices for bench and loopback use.
- Protocol is mode 3: SCLK idles high; data changes on SCLK fall; data is sampled on SCLK rise; the master skips the first fall after SS_n goes low.
- All SPI pins are oversampled by the system clock. Received words go to the fabric; the response word comes from the fabric.

Parameters:
- WIDTH, 16, transaction length in bits (shift register and rx/tx widths).
- SYNC_STAGES, 2, synchronizer flops on SS_n, SCLK and MOSI before edge detect (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- SS_n  in  1  active-low slave select from master
- SCLK  in  1  serial clock from master, idles high
- MOSI  in  1  serial data from master
- MISO  out  1  serial data to master; MSB of shift register
- miso_en  out  1  high while selected; pad tristate enable
- tx_data  in  WIDTH  response word to send in the next transaction
- wrt  in  1  one-clk strobe; captures tx_data into tx_buf
- rx_data  out  WIDTH  last complete received word
- rdy  out  1  high when rx_data holds a new word
- clr_rdy  in  1  clears rdy
- err  out  1  one-clk pulse on an aborted (short or long) transaction

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst is high at a clk edge, all state is set to its reset value:
  - rx_data = 0, tx_buf = 0, shift register = 0.
  - rdy = 0, err = 0, miso_en = 0, MISO = 1.
  - Synchronizer flops for SS_n and SCLK preset to 1; MOSI flops to 0.
  - bit_cnt = 0, state = IDLE.
- Input conditioning: SS_n, SCLK and MOSI each pass through SYNC_STAGES flops, plus one more flop for edge detect.
  - ss_fall, ss_rise, sclk_rise and sclk_fall are single-clk pulses.
  - SCLK high and low phases must each be at least SYNC_STAGES+2 clk cycles.
- tx_buf: wrt loads tx_data at any time; it takes effect at the next SS_n fall. A wrt during a transaction does not disturb the word in flight.
- State machine, 3 states:
  - IDLE:
    - On ss_fall: shift register <= tx_buf, bit_cnt <= 0, rdy <= 0, go to SKIP.
    - Otherwise stay.
  - SKIP (first fall ignored; MSB already on MISO):
    - sclk_rise: mosi_smpl <= synced MOSI, bit_cnt++.
    - sclk_fall: go to SHIFT, no shift.
    - ss_rise: go to IDLE.
  - SHIFT:
    - sclk_rise: mosi_smpl <= MOSI, bit_cnt++.
    - sclk_fall: shift register <= {sr[WIDTH-2:0], mosi_smpl}.
    - ss_rise: go to IDLE.
- Completion on ss_rise, from SKIP or SHIFT:
  - If bit_cnt == WIDTH: rx_data <= {sr[WIDTH-2:0], mosi_smpl} and rdy <= 1 on the same clk edge.
  - Otherwise: rx_data is unchanged, rdy stays 0, and err pulses 1 clk.
- bit_cnt saturates at WIDTH+1 so over-long transactions are flagged.
- Latency: rdy rises SYNC_STAGES+2 clk after the SS_n pin rises.
- MISO = sr[WIDTH-1]. miso_en = (state != IDLE).
- rdy is set/reset. Set has priority over clr_rdy in the same cycle. ss_fall also clears rdy.
- Edge collisions:
  - ss_rise in the same cycle as a sclk edge: ss_rise wins and the sclk edge is ignored.
  - ss_fall while not in IDLE is not possible; ignore it.
- Reset mid-transaction: return to IDLE immediately with no err and no rdy. Activity before the next SS_n fall is ignored.

Decomposition:
- Shared package spi_pkg:
  - spi_state_t enum {IDLE, SKIP, SHIFT}.
  - localparam SPI_WIDTH = 16.
  - Sensor command opcodes used by benches.
- One sub-module, spi_sync_edge: a parameterized synchronizer plus rise/fall pulse generator with a preset value. Instantiate it three times (SS_n, SCLK, MOSI; MOSI uses the level only).
- Remaining logic (shift register, counter, SM, flags) lives in spi_slv16.

Test Plan:
- Basic exchange: wrt with tx_data=16'hA5C3; bench mode-3 master sends 16'h1234 with SCLK half-period 16 clk -> master reads 16'hA5C3, rx_data = 16'h1234, rdy = 1 exactly SYNC_STAGES+2 clk after SS_n rises, err = 0.
- Back-to-back: two transactions sending 16'hFFFF then 16'h0000, with wrt 16'h8001 asserted mid-first-transaction -> first response is the old tx_buf, second response is 16'h8001; rx_data = 16'hFFFF then 16'h0000; rdy clears at the second SS_n fall.
- Short transaction: SS_n rises after 9 SCLK rises -> err pulses 1 clk, rx_data keeps its prior value, rdy = 0. Long transaction (17 rises) -> err pulse.
- rdy priority: clr_rdy held high across completion -> rdy = 1 at completion, 0 one clk after.
- Reset mid-transfer: rst asserted at bit 7 -> MISO = 1, miso_en = 0, rdy = 0, state IDLE. A following full transaction of 16'hBEEF receives correctly.
- Minimum timing: SCLK half-period = SYNC_STAGES+2 clk, random data over 200 words -> all rx_data and MISO words match, with no err.
